// File: rtl/bali_pkg.sv
// rtl/bali_pkg.sv - shared bytecode core types and opcode constants
//
// Purpose:
//    Types and constants shared by the fetch unit, the operand-length decoder
//    and the control unit of the bytecode core.
// Contents:
//    fetch_state_t  fetch sequencer state encoding
//    OP_*           opcode byte values referenced by the core
package bali_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RD_OP = 3'd1,
      ST_RD_A1 = 3'd2,
      ST_RD_A2 = 3'd3,
      ST_ISSUE = 3'd4,
      ST_HALT  = 3'd5
   } fetch_state_t;

   localparam logic [7:0] OP_NOP          = 8'h00;
   localparam logic [7:0] OP_BIPUSH       = 8'h10;
   localparam logic [7:0] OP_SIPUSH       = 8'h11;
   localparam logic [7:0] OP_LDC          = 8'h12;
   localparam logic [7:0] OP_LDC_W        = 8'h13;
   localparam logic [7:0] OP_ILOAD        = 8'h15;
   localparam logic [7:0] OP_ISTORE       = 8'h36;
   localparam logic [7:0] OP_IADD         = 8'h60;
   localparam logic [7:0] OP_IINC         = 8'h84;
   localparam logic [7:0] OP_IFEQ         = 8'h99;
   localparam logic [7:0] OP_GOTO         = 8'hA7;
   localparam logic [7:0] OP_RETURN       = 8'hB1;
   localparam logic [7:0] OP_INVOKESTATIC = 8'hB8;
   localparam logic [7:0] OP_NEWARRAY     = 8'hBC;

endpackage

// File: rtl/bytecode_fetch_if.sv
// rtl/bytecode_fetch_if.sv - program-memory and instruction-issue bus of the fetch unit
//
// Purpose:
//    Bundles the program ROM read port and the fetch-to-control issue
//    handshake into one bus.
// Signals:
//    prog_addr  registered ROM read address (fetch -> ROM)
//    prog_data  ROM byte, valid one cycle after prog_addr (ROM -> fetch)
//    op_code    current opcode (fetch -> control)
//    arg1/arg2  operand bytes, 0 when unused (fetch -> control)
//    op_valid   op_code/arg1/arg2 valid and held until op_done (fetch -> control)
//    op_done    one-cycle retire pulse (control -> fetch)
//    offset     signed branch offset sampled with op_done (control -> fetch)
// Modports:
//    master  fetch unit side
//    slave   ROM/control side
interface bytecode_fetch_if #(
   parameter int ADDR_WIDTH = 16
);

   logic [ADDR_WIDTH-1:0] prog_addr;
   logic [7:0]            prog_data;
   logic [7:0]            op_code;
   logic [7:0]            arg1;
   logic [7:0]            arg2;
   logic                  op_valid;
   logic                  op_done;
   logic [15:0]           offset;

   modport master (
      output prog_addr,
      input  prog_data,
      output op_code,
      output arg1,
      output arg2,
      output op_valid,
      input  op_done,
      input  offset
   );

   modport slave (
      input  prog_addr,
      output prog_data,
      input  op_code,
      input  arg1,
      input  arg2,
      input  op_valid,
      output op_done,
      output offset
   );

endinterface

// File: rtl/oplen_decode.sv
// rtl/oplen_decode.sv - opcode to operand-byte-count decoder
//
// Purpose:
//    Combinational lookup of how many operand bytes follow an opcode.
//    Shared between the fetch unit and the control unit.
// Ports:
//    op_code  in   8  opcode byte
//    len      out  2  number of operand bytes (0, 1 or 2)
module oplen_decode
   import bali_pkg::*;
(
   input  logic [7:0] op_code,
   output logic [1:0] len
);

   always_comb begin
      len = 2'd0;
      // The whole conditional-branch family ifeq..goto carries a 16-bit offset.
      if (op_code >= OP_IFEQ && op_code <= OP_GOTO) begin
         len = 2'd2;
      end else begin
         case (op_code)
            OP_BIPUSH, OP_LDC, OP_ILOAD, OP_ISTORE, OP_NEWARRAY:
               len = 2'd1;
            OP_SIPUSH, OP_LDC_W, OP_IINC, OP_INVOKESTATIC:
               len = 2'd2;
            default:
               len = 2'd0;
         endcase
      end
   end

endmodule

// File: rtl/bytecode_fetch.sv
// rtl/bytecode_fetch.sv - bytecode instruction fetch and PC sequencer
//
// Purpose:
//    Walks program memory from a PC, assembles opcode and operand bytes for
//    each instruction, presents them to control and holds them until control
//    retires the instruction, then advances the PC sequentially or by the
//    branch offset supplied with the retire pulse.
// Parameters:
//    ADDR_WIDTH  program address width; PC arithmetic wraps modulo 2**ADDR_WIDTH
// Ports:
//    clk     in   1           core clock, rising edge
//    rst     in   1           synchronous active-high reset
//    start   in   1           begin execution at PC 0 (IDLE/HALT only)
//    bus     master           ROM read port and instruction-issue handshake
//    pc      out  ADDR_WIDTH  address of the current opcode
//    halted  out  1           high after a return instruction retires
module bytecode_fetch
   import bali_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   bytecode_fetch_if.master      bus,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  halted
);

   fetch_state_t          state;
   fetch_state_t          state_nxt;

   logic [1:0]            dec_len;
   logic [1:0]            len_q;
   logic [7:0]            op_q;
   logic [7:0]            arg1_q;
   logic [7:0]            arg2_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [ADDR_WIDTH-1:0] off_ext;
   logic [ADDR_WIDTH-1:0] next_pc;

   // Length of the byte arriving from the ROM; only meaningful in RD_OP,
   // where that byte is the opcode.
   oplen_decode u_oplen (
      .op_code (bus.prog_data),
      .len     (dec_len)
   );

   // Branch targets are relative to the opcode address, not the byte after
   // the operands; a zero offset means fall through.
   assign off_ext = ADDR_WIDTH'(signed'(bus.offset));
   assign next_pc = (bus.offset != 16'd0) ? pc_q + off_ext
                                          : pc_q + ADDR_WIDTH'(1) + ADDR_WIDTH'(len_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE, ST_HALT: begin
            if (start) state_nxt = ST_RD_OP;
         end
         ST_RD_OP: begin
            state_nxt = (dec_len == 2'd0) ? ST_ISSUE : ST_RD_A1;
         end
         ST_RD_A1: begin
            state_nxt = (len_q == 2'd2) ? ST_RD_A2 : ST_ISSUE;
         end
         ST_RD_A2: begin
            state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            // start is deliberately not looked at here: a retire always wins.
            if (bus.op_done) state_nxt = (op_q == OP_RETURN) ? ST_HALT : ST_RD_OP;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // The ROM address streams forward one byte per read cycle so each operand
   // byte lands exactly one cycle after its address; the byte read after the
   // last operand is simply dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         addr_q <= '0;
         op_q   <= 8'd0;
         arg1_q <= 8'd0;
         arg2_q <= 8'd0;
         len_q  <= 2'd0;
      end else begin
         case (state)
            ST_IDLE, ST_HALT: begin
               if (start) begin
                  pc_q   <= '0;
                  addr_q <= '0;
                  arg1_q <= 8'd0;
                  arg2_q <= 8'd0;
               end
            end
            ST_RD_OP: begin
               op_q   <= bus.prog_data;
               len_q  <= dec_len;
               addr_q <= addr_q + ADDR_WIDTH'(1);
            end
            ST_RD_A1: begin
               arg1_q <= bus.prog_data;
               addr_q <= addr_q + ADDR_WIDTH'(1);
            end
            ST_RD_A2: begin
               arg2_q <= bus.prog_data;
               addr_q <= addr_q + ADDR_WIDTH'(1);
            end
            ST_ISSUE: begin
               if (bus.op_done) begin
                  pc_q   <= next_pc;
                  addr_q <= next_pc;
                  // Clear operands now so a shorter next instruction never
                  // shows stale bytes in its unused slots.
                  arg1_q <= 8'd0;
                  arg2_q <= 8'd0;
               end
            end
            default: begin
               pc_q <= pc_q;
            end
         endcase
      end
   end

   assign bus.prog_addr = addr_q;
   assign bus.op_code   = op_q;
   assign bus.arg1      = arg1_q;
   assign bus.arg2      = arg2_q;
   assign bus.op_valid  = (state == ST_ISSUE);
   assign pc            = pc_q;
   assign halted        = (state == ST_HALT);

endmodule

// File: tb/tb_bytecode_fetch.sv
// tb/tb_bytecode_fetch.sv - self-checking bench for bytecode_fetch
module tb_bytecode_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] pc;
   logic        halted;

   logic [7:0]  rom [0:65535];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  op;
      logic [7:0]  a1;
      logic [7:0]  a2;
      logic [15:0] pc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];

   bytecode_fetch_if #(.ADDR_WIDTH(16)) bus ();

   assign bus.prog_data = rom[bus.prog_addr];

   bytecode_fetch #(.ADDR_WIDTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus),
      .pc     (pc),
      .halted (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic expect_op(input logic [7:0] op, input logic [7:0] a1, input logic [7:0] a2,
                            input logic [15:0] epc, input int lat);
      exp_t e;
      e.op = op; e.a1 = a1; e.a2 = a2; e.pc = epc; e.lat = lat;
      exp_q.push_back(e);
   endtask

   // Drive start and/or a retire pulse, then wait for the next issued
   // instruction and compare it with the head of the scoreboard.
   task automatic fire(input bit use_start, input bit use_done, input logic [15:0] off,
                       input bit stray);
      int   n;
      exp_t e;
      start       = use_start;
      bus.op_done = use_done;
      bus.offset  = off;
      tick;
      start       = 1'b0;
      bus.op_done = 1'b0;
      bus.offset  = 16'd0;
      n = 1;
      while (!bus.op_valid && n < 40) begin
         bus.op_done = stray && (n == 2);
         tick;
         n++;
      end
      bus.op_done = 1'b0;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard_empty observed=0 expected=1");
      end else begin
         e = exp_q.pop_front();
         check("op_valid_rise", 32'(bus.op_valid), 32'd1);
         check("latency", 32'(n), 32'(e.lat));
         check("op_code", 32'(bus.op_code), 32'(e.op));
         check("arg1", 32'(bus.arg1), 32'(e.a1));
         check("arg2", 32'(bus.arg2), 32'(e.a2));
         check("pc", 32'(pc), 32'(e.pc));
      end
   endtask

   task automatic retire_to_halt(input logic [15:0] exp_pc);
      bus.op_done = 1'b1;
      tick;
      bus.op_done = 1'b0;
      check("halted", 32'(halted), 32'd1);
      check("halt_op_valid", 32'(bus.op_valid), 32'd0);
      check("halt_pc", 32'(pc), 32'(exp_pc));
   endtask

   initial begin
      logic [7:0]  s_op;
      logic [7:0]  s_a1;
      logic [7:0]  s_a2;
      logic [15:0] s_pc;
      bit          stable;

      for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
      rst         = 1'b1;
      start       = 1'b0;
      bus.op_done = 1'b0;
      bus.offset  = 16'd0;
      tick;
      tick;
      rst = 1'b0;
      check("rst_pc", 32'(pc), 32'd0);
      check("rst_prog_addr", 32'(bus.prog_addr), 32'd0);
      check("rst_op_valid", 32'(bus.op_valid), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_op_code", 32'(bus.op_code), 32'd0);

      // Reset in the middle of fetching a one-operand instruction.
      rom[0] = 8'h10;
      rom[1] = 8'hAA;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      check("midfetch_op_code", 32'(bus.op_code), 32'h10);
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
      check("midrst_op_code", 32'(bus.op_code), 32'd0);
      check("midrst_arg1", 32'(bus.arg1), 32'd0);
      check("midrst_prog_addr", 32'(bus.prog_addr), 32'd0);
      check("midrst_pc", 32'(pc), 32'd0);
      check("midrst_op_valid", 32'(bus.op_valid), 32'd0);
      check("midrst_halted", 32'(halted), 32'd0);
      tick;
      tick;
      check("midrst_idle", 32'(bus.op_valid), 32'd0);

      // Program A: 02, 05, 10 07, 60, B1
      rom[0] = 8'h02; rom[1] = 8'h05; rom[2] = 8'h10; rom[3] = 8'h07;
      rom[4] = 8'h60; rom[5] = 8'hB1;
      expect_op(8'h02, 8'h00, 8'h00, 16'd0, 2);
      expect_op(8'h05, 8'h00, 8'h00, 16'd1, 2);
      expect_op(8'h10, 8'h07, 8'h00, 16'd2, 3);
      expect_op(8'h60, 8'h00, 8'h00, 16'd4, 2);
      expect_op(8'hB1, 8'h00, 8'h00, 16'd5, 2);
      fire(1'b1, 1'b0, 16'd0, 1'b0);
      for (int k = 0; k < 4; k++) fire(1'b0, 1'b1, 16'd0, 1'b0);
      retire_to_halt(16'd6);

      // Program B: sipush, nops, goto with negative offset, return.
      for (int i = 0; i < 16; i++) rom[i] = 8'h00;
      rom[0] = 8'h11; rom[1] = 8'h12; rom[2] = 8'h34;
      rom[8] = 8'hA7; rom[9] = 8'hFF; rom[10] = 8'hFD;
      rom[11] = 8'hB1;
      expect_op(8'h11, 8'h12, 8'h34, 16'd0, 4);
      fire(1'b1, 1'b0, 16'd0, 1'b0);
      // start together with op_done in ISSUE: the retire must win.
      expect_op(8'h00, 8'h00, 8'h00, 16'd3, 2);
      fire(1'b1, 1'b1, 16'd0, 1'b0);
      for (int p = 4; p < 8; p++) begin
         expect_op(8'h00, 8'h00, 8'h00, 16'(p), 2);
         fire(1'b0, 1'b1, 16'd0, 1'b0);
      end
      // Stray op_done lands while the first operand is being read.
      expect_op(8'hA7, 8'hFF, 8'hFD, 16'd8, 4);
      fire(1'b0, 1'b1, 16'd0, 1'b1);

      s_op = bus.op_code; s_a1 = bus.arg1; s_a2 = bus.arg2; s_pc = pc;
      stable = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick;
         if (!bus.op_valid || bus.op_code !== s_op || bus.arg1 !== s_a1 ||
             bus.arg2 !== s_a2 || pc !== s_pc) stable = 1'b0;
      end
      check("hold_stable", 32'(stable), 32'd1);
      check("hold_op_code", 32'(bus.op_code), 32'hA7);

      expect_op(8'h00, 8'h00, 8'h00, 16'd5, 2);
      fire(1'b0, 1'b1, 16'hFFFD, 1'b0);
      for (int p = 6; p < 8; p++) begin
         expect_op(8'h00, 8'h00, 8'h00, 16'(p), 2);
         fire(1'b0, 1'b1, 16'd0, 1'b0);
      end
      expect_op(8'hA7, 8'hFF, 8'hFD, 16'd8, 4);
      fire(1'b0, 1'b1, 16'd0, 1'b0);
      expect_op(8'hB1, 8'h00, 8'h00, 16'd11, 2);
      fire(1'b0, 1'b1, 16'd0, 1'b0);
      retire_to_halt(16'd12);

      // Program C: branch backwards across address 0 and fall through the top.
      rom[0] = 8'hA7; rom[1] = 8'hFF; rom[2] = 8'hFE;
      rom[16'hFFFE] = 8'h10; rom[16'hFFFF] = 8'h55;
      expect_op(8'hA7, 8'hFF, 8'hFE, 16'd0, 4);
      fire(1'b1, 1'b0, 16'd0, 1'b0);
      expect_op(8'h10, 8'h55, 8'h00, 16'hFFFE, 3);
      fire(1'b0, 1'b1, 16'hFFFE, 1'b0);
      expect_op(8'hA7, 8'hFF, 8'hFE, 16'd0, 4);
      fire(1'b0, 1'b1, 16'd0, 1'b0);
      expect_op(8'h10, 8'h55, 8'h00, 16'hFFFE, 3);
      fire(1'b0, 1'b1, 16'hFFFE, 1'b0);

      // Reset while issuing, with a retire pulse in the same cycle.
      rst         = 1'b1;
      bus.op_done = 1'b1;
      tick;
      rst         = 1'b0;
      bus.op_done = 1'b0;
      check("issue_rst_op_valid", 32'(bus.op_valid), 32'd0);
      check("issue_rst_pc", 32'(pc), 32'd0);
      check("issue_rst_prog_addr", 32'(bus.prog_addr), 32'd0);
      check("issue_rst_op_code", 32'(bus.op_code), 32'd0);
      check("issue_rst_arg1", 32'(bus.arg1), 32'd0);
      check("issue_rst_halted", 32'(halted), 32'd0);
      tick;
      tick;
      tick;
      check("issue_rst_idle", 32'(bus.op_valid), 32'd0);
      check("issue_rst_idle_addr", 32'(bus.prog_addr), 32'd0);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
